fb_rect_fill: RTL and testbench

- Hardware rectangle-fill engine that drives the frame-buffer write port (mem_write / mem_addr / mem_wdata) in the clk_cpu domain.
- The CPU latches a rectangle and a 12-bit colour with one start pulse. The engine then issues one pixel write per granted cycle, in row-major order, into the 320x240 linear frame buffer.
- It sits between the CPU bus and an external write arbiter. Addressing is addr = y*FB_W + x.

---
 rtl/fb_rect_fill.sv | 162 ++++++++++++++++
 tb/tb_fb_rect_fill.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: writes a solid colour rectangle into a 320x240 linear frame buffer, one pixel per granted cycle.
// Optional macro FB_FILL_CLIP_EN clips the rectangle to the screen instead of rejecting out-of-range starts with err.
module fb_rect_fill #(
    parameter int unsigned FB_W   = 320,
    parameter int unsigned FB_H   = 240,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk_cpu,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [8:0]        x_in,
    input  logic [8:0]        y_in,
    input  logic [8:0]        w_in,
    input  logic [8:0]        h_in,
    input  logic [11:0]       color_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_write,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata
);

    localparam logic [9:0]        FB_W10 = 10'(FB_W);
    localparam logic [9:0]        FB_H10 = 10'(FB_H);
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t            state;
    logic [8:0]        x_r, y_r, w_r, h_r;
    logic [11:0]       color_r;
    logic [8:0]        w_last, h_last;
    logic [8:0]        col_cnt, row_cnt;
    logic [ADDR_W-1:0] row_base;

    logic [9:0]        x10, y10, w10, h10;
    logic [8:0]        w_eff_c, h_eff_c;
    logic              reject_c;
    logic [ADDR_W-1:0] base_c;

    always_comb begin
        x10      = {1'b0, x_r};
        y10      = {1'b0, y_r};
        w10      = {1'b0, w_r};
        h10      = {1'b0, h_r};
        w_eff_c  = w_r;
        h_eff_c  = h_r;
        reject_c = 1'b0;
        base_c   = ADDR_W'(y_r) * FB_W_A + ADDR_W'(x_r);
`ifdef FB_FILL_CLIP_EN
        // An origin off-screen collapses to an empty rectangle, which SETUP finishes as a normal done.
        if (x10 >= FB_W10)
            w_eff_c = '0;
        else if (w10 > FB_W10 - x10)
            w_eff_c = 9'(FB_W10 - x10);
        if (y10 >= FB_H10)
            h_eff_c = '0;
        else if (h10 > FB_H10 - y10)
            h_eff_c = 9'(FB_H10 - y10);
`else
        reject_c = ((x10 + w10) > FB_W10) || ((y10 + h10) > FB_H10);
`endif
    end

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            x_r       <= '0;
            y_r       <= '0;
            w_r       <= '0;
            h_r       <= '0;
            color_r   <= '0;
            w_last    <= '0;
            h_last    <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            row_base  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r     <= x_in;
                        y_r     <= y_in;
                        w_r     <= w_in;
                        h_r     <= h_in;
                        color_r <= color_in;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    col_cnt <= '0;
                    row_cnt <= '0;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (reject_c) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (w_eff_c == '0 || h_eff_c == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        w_last    <= w_eff_c - 9'd1;
                        h_last    <= h_eff_c - 9'd1;
                        row_base  <= base_c;
                        mem_addr  <= base_c;
                        mem_wdata <= {20'b0, color_r};
                        mem_write <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    // mem_addr is kept as a register equal to row_base + col_cnt so mem_gnt never reaches an output combinationally.
                    if (abort) begin
                        mem_write <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (mem_gnt) begin
                        if (col_cnt != w_last) begin
                            col_cnt  <= col_cnt + 9'd1;
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end else if (row_cnt != h_last) begin
                            col_cnt  <= '0;
                            row_cnt  <= row_cnt + 9'd1;
                            row_base <= row_base + FB_W_A;
                            mem_addr <= row_base + FB_W_A;
                        end else begin
                            mem_write <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    mem_write <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed self-checking bench for fb_rect_fill; cycle 0 is the cycle in which start is sampled high.
module tb_fb_rect_fill;

    logic        clk_cpu = 1'b0;
    logic        reset_n;
    logic        start, abort, mem_gnt;
    logic [8:0]  x_in, y_in, w_in, h_in;
    logic [11:0] color_in;
    logic        busy, done, err, mem_write;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;

    fb_rect_fill #(.FB_W(320), .FB_H(240), .ADDR_W(17)) dut (
        .clk_cpu   (clk_cpu),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .x_in      (x_in),
        .y_in      (y_in),
        .w_in      (w_in),
        .h_in      (h_in),
        .color_in  (color_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_write (mem_write),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    always #5 clk_cpu = ~clk_cpu;

    int n_cmp = 0;
    int n_bad = 0;

    int          nwr, done_cyc, err_cyc, first_wr, last_wr, busy_done, busy1;
    int          abort_cyc, mw_after, busy_after, hold_bad;
    logic [31:0] aq[$];
    logic [31:0] dq[$];
    int          exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic check_addrs(input string tag);
        check({tag, "_count"}, aq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), (i < aq.size()) ? aq[i] : 32'hFFFF_FFFF, exp_q[i]);
    endtask

    // gmode 0: grant always; 1: grant low on even cycles (cycle 2 low).
    task automatic fill(input logic [8:0] x, input logic [8:0] y, input logic [8:0] w, input logic [8:0] h,
                        input logic [11:0] c, input int gmode, input int abort_after, input int restart_cyc);
        int          idle_cnt;
        bit          finished;
        bit          prev_stall;
        logic [31:0] prev_addr;
        aq.delete();
        dq.delete();
        nwr = 0; done_cyc = -1; err_cyc = -1; first_wr = -1; last_wr = -1;
        busy_done = -1; busy1 = -1; abort_cyc = -1; mw_after = -1; busy_after = -1; hold_bad = 0;
        idle_cnt = 0; finished = 0; prev_stall = 0; prev_addr = '0;
        x_in = x; y_in = y; w_in = w; h_in = h; color_in = c;
        start = 1'b1; abort = 1'b0; mem_gnt = 1'b1;
        @(posedge clk_cpu); #1;
        for (int cyc = 1; cyc < 300; cyc++) begin
            start = 1'b0;
            abort = 1'b0;
            mem_gnt = (gmode == 0) ? 1'b1 : ((cyc % 2) == 1);
            if (cyc == restart_cyc) begin
                start = 1'b1; x_in = 9'd100; y_in = 9'd100; w_in = 9'd4; h_in = 9'd4;
            end
            if (cyc == 1) busy1 = busy;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                mw_after = mem_write; busy_after = busy;
            end
            if (prev_stall && mem_write && mem_addr != prev_addr) hold_bad++;
            prev_stall = mem_write && !mem_gnt;
            prev_addr  = mem_addr;
            if (done) begin done_cyc = cyc; busy_done = busy; end
            if (err) err_cyc = cyc;
            if (mem_write && mem_gnt) begin
                aq.push_back(mem_addr);
                dq.push_back(mem_wdata);
                nwr++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (nwr == abort_after) begin abort = 1'b1; abort_cyc = cyc; end
            end
            if (!busy && cyc > 1) idle_cnt++;
            if (idle_cnt == 4) begin finished = 1; break; end
            @(posedge clk_cpu); #1;
        end
        start = 1'b0; abort = 1'b0; mem_gnt = 1'b1;
        check("fill_terminates", finished, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; mem_gnt = 1'b1;
        x_in = '0; y_in = '0; w_in = '0; h_in = '0; color_in = '0;
        repeat (3) @(posedge clk_cpu);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;
        @(posedge clk_cpu); #1;

        // Basic fill with continuous grant
        fill(9'd10, 9'd20, 9'd3, 9'd2, 12'hF00, 0, -1, -1);
        exp_q = {6410, 6411, 6412, 6730, 6731, 6732};
        check_addrs("basic");
        check("basic_busy_c1", busy1, 1);
        check("basic_first_wr", first_wr, 2);
        check("basic_last_wr", last_wr, 7);
        check("basic_done_cyc", done_cyc, 8);
        check("basic_busy_at_done", busy_done, 0);
        check("basic_wdata0", dq.size() > 0 ? dq[0] : 32'hFFFF_FFFF, 32'h0000_0F00);
        check("basic_wdata5", dq.size() > 5 ? dq[5] : 32'hFFFF_FFFF, 32'h0000_0F00);
        check("basic_err", err_cyc, -1);

        // Backpressure: grant alternates, low on the first write cycle
        fill(9'd10, 9'd20, 9'd3, 9'd2, 12'hF00, 1, -1, -1);
        check_addrs("bp");
        check("bp_first_wr", first_wr, 3);
        check("bp_last_wr", last_wr, 13);
        check("bp_done_cyc", done_cyc, 14);
        check("bp_hold", hold_bad, 0);

        // Zero width
        fill(9'd5, 9'd5, 9'd0, 9'd5, 12'h0AB, 0, -1, -1);
        check("zero_writes", nwr, 0);
        check("zero_done_cyc", done_cyc, 2);
        check("zero_err", err_cyc, -1);

        // Second start during FILL must be ignored
        fill(9'd0, 9'd0, 9'd2, 9'd1, 12'h123, 0, -1, 3);
        exp_q = {0, 1};
        check_addrs("busy_start");
        check("busy_start_done", done_cyc, 4);
        check("busy_start_wdata", dq.size() > 1 ? dq[1] : 32'hFFFF_FFFF, 32'h0000_0123);

        // Bottom-right edge
        fill(9'd318, 9'd239, 9'd5, 9'd3, 12'h0F0, 0, -1, -1);
`ifdef FB_FILL_CLIP_EN
        exp_q = {76798, 76799};
        check_addrs("edge_clip");
        check("edge_clip_done", done_cyc, 4);
        check("edge_clip_err", err_cyc, -1);
`else
        check("edge_rej_writes", nwr, 0);
        check("edge_rej_err_cyc", err_cyc, 2);
        check("edge_rej_done", done_cyc, -1);
`endif

        // Abort in the same cycle as the 5th granted write
        fill(9'd0, 9'd0, 9'd4, 9'd4, 12'h00F, 0, 5, -1);
        exp_q = {0, 1, 2, 3, 320};
        check_addrs("abort");
        check("abort_cyc", abort_cyc, 6);
        check("abort_mw_after", mw_after, 0);
        check("abort_busy_after", busy_after, 0);
        check("abort_no_done", done_cyc, -1);

        // Abort while idle has no effect
        abort = 1'b1;
        @(posedge clk_cpu); #1;
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_mw", mem_write, 0);

        // Asynchronous reset mid-fill
        x_in = 9'd0; y_in = 9'd0; w_in = 9'd4; h_in = 9'd4; color_in = 12'hFFF;
        start = 1'b1; mem_gnt = 1'b1;
        @(posedge clk_cpu); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk_cpu); #1; end
        check("midrst_pre_mw", mem_write, 1);
        check("midrst_pre_addr", mem_addr, 2);
        reset_n = 1'b0;
        #1;
        check("midrst_mw", mem_write, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(posedge clk_cpu); #1;
        reset_n = 1'b1;
        @(posedge clk_cpu); #1;
        check("post_rst_idle_mw", mem_write, 0);
        fill(9'd10, 9'd20, 9'd3, 9'd2, 12'hF00, 0, -1, -1);
        exp_q = {6410, 6411, 6412, 6730, 6731, 6732};
        check_addrs("post_rst");
        check("post_rst_done", done_cyc, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
